// File: rtl/iter_div_unit.sv
// Multi-cycle restoring radix-2 divider with start/busy/done handshake.
// Produces quotient (LO) and remainder (HI), signed or unsigned, with flush abort.
module iter_div_unit #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;      // dividend bits shift out of the top, quotient bits shift in
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] prem;
  logic             neg_q;
  logic             neg_r;

  logic             accept;
  logic             dvd_neg;
  logic             dsr_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  generate
    if (SIGNED_EN) begin : g_signed
      assign dvd_neg = is_signed & dividend[WIDTH-1];
      assign dsr_neg = is_signed & divisor[WIDTH-1];
      assign dvd_mag = dvd_neg ? -dividend : dividend;
      assign dsr_mag = dsr_neg ? -divisor : divisor;
    end else begin : g_unsigned
      logic unused_is_signed;
      assign unused_is_signed = is_signed;
      assign dvd_neg = 1'b0;
      assign dsr_neg = 1'b0;
      assign dvd_mag = dividend;
      assign dsr_mag = divisor;
    end
  endgenerate

  assign accept  = start & ~flush & ((state == IDLE) | (state == DONE));
  assign shifted = {prem, acc[WIDTH-1]};
  assign diff    = shifted - {1'b0, dsr};

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) state_next = (divisor == '0) ? DONE : CALC;
          else       state_next = IDLE;
        end
        CALC:    if (cnt == '0) state_next = FIX;
        FIX:     state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      acc         <= '0;
      dsr         <= '0;
      prem        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      busy <= (state_next == CALC) || (state_next == FIX);
      done <= (state_next == DONE);
      if (accept) begin
        if (divisor == '0) begin
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end else begin
          acc   <= dvd_mag;
          dsr   <= dsr_mag;
          prem  <= '0;
          cnt   <= CW'(WIDTH - 1);
          neg_q <= dvd_neg ^ dsr_neg;
          neg_r <= dvd_neg;
        end
      end else if (!flush && state == CALC) begin
        // Restoring step: keep the difference only when it did not go negative
        if (!diff[WIDTH]) begin
          prem <= diff[WIDTH-1:0];
          acc  <= {acc[WIDTH-2:0], 1'b1};
        end else begin
          prem <= shifted[WIDTH-1:0];
          acc  <= {acc[WIDTH-2:0], 1'b0};
        end
        if (cnt != '0) cnt <= cnt - 1'b1;
      end else if (!flush && state == FIX) begin
        quotient    <= neg_q ? -acc : acc;
        remainder   <= neg_r ? -prem : prem;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iter_div_unit.sv
// Directed bench for iter_div_unit: 32-bit signed instance and 8-bit unsigned-only instance.
module tb_iter_div_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        flush = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  logic        n_start = 1'b0;
  logic        n_is_signed = 1'b0;
  logic [7:0]  n_dividend = '0;
  logic [7:0]  n_divisor = '0;
  logic        n_flush = 1'b0;
  logic        n_busy, n_done, n_div_by_zero;
  logic [7:0]  n_quotient, n_remainder;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  iter_div_unit #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .flush(flush), .busy(busy),
    .done(done), .div_by_zero(div_by_zero), .quotient(quotient), .remainder(remainder)
  );

  iter_div_unit #(.WIDTH(8), .SIGNED_EN(1'b0)) dut_n (
    .clock(clock), .reset_n(reset_n), .start(n_start), .is_signed(n_is_signed),
    .dividend(n_dividend), .divisor(n_divisor), .flush(n_flush), .busy(n_busy),
    .done(n_done), .div_by_zero(n_div_by_zero), .quotient(n_quotient), .remainder(n_remainder)
  );

  // Issue one divide on the 32-bit unit; returns edges until done and busy violations seen.
  task automatic do_div32(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_err);
    @(negedge clock);
    is_signed = sgn; dividend = a; divisor = b; start = 1'b1;
    lat = 0; busy_err = 0;
    do begin
      @(posedge clock); #1;
      lat++;
      if (lat == 1) start = 1'b0;
      if (!done && busy !== 1'b1) busy_err++;
      if (done && busy !== 1'b0) busy_err++;
    end while (done !== 1'b1 && lat < 200);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b dbz=%b q=%h r=%h, want all 0", busy, done, div_by_zero, quotient, remainder);
    end
    repeat (2) @(posedge clock);
    @(negedge clock); reset_n = 1'b1;
    $display("reset: released");
  endtask

  task automatic test_unsigned();
    int lat, be;
    do_div32(1'b0, 32'd100, 32'd7, lat, be);
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL unsigned_latency: got %0d want 34", lat); end
    checks++;
    if (be !== 0) begin errors++; $display("FAIL unsigned_busy: %0d bad cycles want 0", be); end
    checks++;
    if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL unsigned_result: q=%0d r=%0d dbz=%b want 14 2 0", quotient, remainder, div_by_zero);
    end
    @(posedge clock); #1;
    checks++;
    if (done !== 1'b0 || quotient !== 32'd14) begin
      errors++; $display("FAIL done_pulse: done=%b q=%0d want 0 14", done, quotient);
    end
    $display("unsigned 100/7: lat=%0d q=%0d r=%0d", lat, quotient, remainder);
  endtask

  task automatic test_signed();
    int lat, be;
    do_div32(1'b1, 32'hFFFF_FFF9, 32'd2, lat, be);
    checks++;
    if (quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF || lat !== 34) begin
      errors++; $display("FAIL signed_m7_2: q=%h r=%h lat=%0d want fffffffd ffffffff 34", quotient, remainder, lat);
    end
    $display("signed -7/2: q=%h r=%h", quotient, remainder);
    do_div32(1'b0, 32'hFFFF_FFF9, 32'd2, lat, be);
    checks++;
    if (quotient !== 32'h7FFF_FFFC || remainder !== 32'd1) begin
      errors++; $display("FAIL unsigned_fff9_2: q=%h r=%h want 7ffffffc 00000001", quotient, remainder);
    end
    $display("unsigned fffffff9/2: q=%h r=%h", quotient, remainder);
    do_div32(1'b1, 32'd7, 32'hFFFF_FFFE, lat, be);
    checks++;
    if (quotient !== 32'hFFFF_FFFD || remainder !== 32'd1) begin
      errors++; $display("FAIL signed_7_m2: q=%h r=%h want fffffffd 00000001", quotient, remainder);
    end
    $display("signed 7/-2: q=%h r=%h", quotient, remainder);
  endtask

  task automatic test_overflow();
    int lat, be;
    do_div32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, be);
    checks++;
    if (quotient !== 32'h8000_0000 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL signed_overflow: q=%h r=%h dbz=%b want 80000000 0 0", quotient, remainder, div_by_zero);
    end
    $display("signed min/-1: q=%h r=%h", quotient, remainder);
  endtask

  task automatic test_busy_start();
    int lat;
    @(negedge clock);
    is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    lat = 0;
    do begin
      @(posedge clock); #1;
      lat++;
      if (lat == 1) start = 1'b0;
      if (lat == 5) begin dividend = 32'd1000; divisor = 32'd0; start = 1'b1; end
      if (lat == 6) start = 1'b0;
    end while (done !== 1'b1 && lat < 200);
    checks++;
    if (lat !== 34 || quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL busy_start: lat=%0d q=%0d r=%0d dbz=%b want 34 14 2 0", lat, quotient, remainder, div_by_zero);
    end
    $display("busy start ignored: lat=%0d q=%0d r=%0d", lat, quotient, remainder);
  endtask

  task automatic test_flush();
    int lat, be, dcount;
    do_div32(1'b0, 32'd50, 32'd5, lat, be);
    checks++;
    if (quotient !== 32'd10 || remainder !== 32'd0) begin
      errors++; $display("FAIL flush_prior: q=%0d r=%0d want 10 0", quotient, remainder);
    end
    @(negedge clock);
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (8) @(posedge clock);
    @(negedge clock); flush = 1'b1;
    @(negedge clock); flush = 1'b0;
    dcount = 0;
    repeat (40) begin @(posedge clock); #1; if (done) dcount++; end
    checks++;
    if (dcount !== 0 || quotient !== 32'd10 || remainder !== 32'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_abort: dones=%0d q=%0d r=%0d busy=%b want 0 10 0 0", dcount, quotient, remainder, busy);
    end
    $display("flush mid-divide: dones=%0d q=%0d r=%0d", dcount, quotient, remainder);
    @(negedge clock);
    dividend = 32'd20; divisor = 32'd0; start = 1'b1; flush = 1'b1;
    @(negedge clock); start = 1'b0; flush = 1'b0;
    dcount = 0;
    repeat (5) begin @(posedge clock); #1; if (done || busy) dcount++; end
    checks++;
    if (dcount !== 0 || div_by_zero !== 1'b0 || quotient !== 32'd10) begin
      errors++; $display("FAIL flush_wins: activity=%0d dbz=%b q=%0d want 0 0 10", dcount, div_by_zero, quotient);
    end
    $display("flush with start: activity=%0d", dcount);
    do_div32(1'b0, 32'd9, 32'd3, lat, be);
    checks++;
    if (lat !== 34 || quotient !== 32'd3 || remainder !== 32'd0) begin
      errors++; $display("FAIL after_flush: lat=%0d q=%0d r=%0d want 34 3 0", lat, quotient, remainder);
    end
    $display("9/3 after flush: lat=%0d q=%0d r=%0d", lat, quotient, remainder);
  endtask

  task automatic test_div_zero();
    int lat, be;
    do_div32(1'b0, 32'd1234, 32'd0, lat, be);
    checks++;
    if (lat !== 1 || be !== 0) begin
      errors++; $display("FAIL dbz_timing: lat=%0d busy_err=%0d want 1 0", lat, be);
    end
    checks++;
    if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd1234 || div_by_zero !== 1'b1) begin
      errors++; $display("FAIL dbz_result: q=%h r=%0d dbz=%b want ffffffff 1234 1", quotient, remainder, div_by_zero);
    end
    $display("1234/0: lat=%0d q=%h r=%0d dbz=%b", lat, quotient, remainder, div_by_zero);
  endtask

  task automatic test_reset_mid();
    int dcount;
    @(negedge clock);
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (14) @(posedge clock);
    @(negedge clock); reset_n = 1'b0;
    #1;
    checks++;
    if (quotient !== 32'd0 || remainder !== 32'd0 || div_by_zero !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_mid: q=%h r=%h dbz=%b busy=%b done=%b want all 0", quotient, remainder, div_by_zero, busy, done);
    end
    @(negedge clock); reset_n = 1'b1;
    dcount = 0;
    repeat (40) begin @(posedge clock); #1; if (done) dcount++; end
    checks++;
    if (dcount !== 0) begin errors++; $display("FAIL reset_no_done: dones=%0d want 0", dcount); end
    $display("reset mid-divide: dones after release=%0d", dcount);
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clock);
    n_is_signed = 1'b1; n_dividend = 8'hF0; n_divisor = 8'h10; n_start = 1'b1;
    lat = 0;
    do begin
      @(posedge clock); #1;
      lat++;
      if (lat == 1) n_start = 1'b0;
    end while (n_done !== 1'b1 && lat < 100);
    checks++;
    if (lat !== 10 || n_quotient !== 8'h0F || n_remainder !== 8'h00) begin
      errors++; $display("FAIL narrow_unsigned: lat=%0d q=%h r=%h want 10 0f 00", lat, n_quotient, n_remainder);
    end
    $display("w8 f0/10: lat=%0d q=%h r=%h", lat, n_quotient, n_remainder);
    n_dividend = 8'h07; n_divisor = 8'h02; n_start = 1'b1;
    lat = 0;
    do begin
      @(posedge clock); #1;
      lat++;
      if (lat == 1) n_start = 1'b0;
    end while (n_done !== 1'b1 && lat < 100);
    checks++;
    if (lat !== 10 || n_quotient !== 8'h03 || n_remainder !== 8'h01) begin
      errors++; $display("FAIL back_to_back: lat=%0d q=%h r=%h want 10 03 01", lat, n_quotient, n_remainder);
    end
    $display("w8 back-to-back 07/02: lat=%0d q=%h r=%h", lat, n_quotient, n_remainder);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_busy_start();
    test_flush();
    test_div_zero();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iter_div_unit.md
# iter_div_unit

Parametrised multi-cycle integer divider. It replaces the single-cycle divide path in the execute stage and produces the quotient and remainder destined for the LO and HI registers. It uses a start/busy/done handshake, so the hazard unit stalls MFHI/MFLO until the result is ready. It also supports signed and unsigned modes, a divide-by-zero fast path, and abort on pipeline flush.

## Interface
- WIDTH, 32, operand and result width in bits (≥ 4).
- SIGNED_EN, 1, when 0 the signed mode logic is removed and `is_signed` is ignored (unsigned only).
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new divide; sampled only when `busy`=0.
- is_signed  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with `start`.
- dividend  in  WIDTH  numerator; sampled with `start`.
- divisor  in  WIDTH  denominator; sampled with `start`.
- flush  in  1  abort any in-flight divide (branch squash / flush_e).
- busy  out  1  a divide is in flight; new `start` is ignored.
- done  out  1  one-cycle pulse; `quotient`/`remainder` are valid from this cycle onward.
- div_by_zero  out  1  the last completed divide had divisor = 0; valid with `done`, held afterwards.
- quotient  out  WIDTH  result for LO; held until the next `done`.
- remainder  out  WIDTH  result for HI; held until the next `done`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- **Reset (async, `reset_n`=0):**
  - state ← IDLE; cycle counter ← 0.
  - `busy`, `done`, `div_by_zero` ← 0; `quotient`, `remainder` ← 0.
- **IDLE / DONE with `start`=1 and `flush`=0:**
  - Latch the operands and the effective signed flag (`is_signed` & SIGNED_EN).
  - Divisor = 0 → go to DONE next cycle with:
    - `quotient` = all-ones;
    - `remainder` = `dividend` (unmodified);
    - `div_by_zero` = 1.
  - Divisor ≠ 0 →
    - Signed mode: take the magnitudes of both operands.
    - Clear the partial remainder; counter ← WIDTH−1; go to CALC.
- **CALC:** one restoring radix-2 step per cycle.
  - Shift the partial remainder left with the next dividend MSB.
  - Trial subtract, WIDTH+1 bits wide.
  - Non-negative result → keep the difference and shift a 1 into the quotient; negative → shift a 0.
  - Counter = 0 → go to FIX; otherwise decrement.
- **FIX:**
  - Signed mode: negate the quotient if the dividend sign XOR the divisor sign is 1; negate the remainder if the dividend was negative.
  - Register the results; go to DONE.
- **DONE:**
  - `done`=1 for exactly this cycle.
  - No `start` → return to IDLE; a `start` here is accepted (back-to-back operation).
- **Signed overflow:** MIN / −1 gives `quotient` = MIN and `remainder` = 0. This falls out of the magnitude arithmetic and needs no special case.
- **`flush`=1 in any state:**
  - Next state IDLE; no `done` is produced.
  - `quotient`, `remainder`, `div_by_zero` keep their previous completed values.
  - A `start` in the same cycle is ignored (flush wins).
- **`start` while `busy`=1:** ignored; the in-flight operation is unaffected.

## Timing
- `busy` = 1 in CALC and FIX, and is registered. It rises in the cycle after the accepted `start` edge.
- **Normal divide latency:**
  - `start` sampled at edge k.
  - CALC occupies cycles k+1 … k+WIDTH; FIX is cycle k+WIDTH+1.
  - `done` = 1 in cycle k+WIDTH+2, so `done` rises WIDTH+2 edges after `start`.
- **Divide by zero:** `done` rises 1 edge after `start`; `busy` never asserts.
- **Outputs:** results update on the same edge that raises `done`, and are stable until the next `done` edge.
- **Back-to-back:** a `start` during the `done` cycle gives the next `done` exactly WIDTH+2 cycles later. There is no idle bubble.
- **Reset mid-operation:** all outputs go to 0 immediately (asynchronously). No `done` appears after `reset_n` is released.

## Test plan
- WIDTH=32, unsigned 100 / 7, `start` at edge 0:
  - `busy`=1 during cycles 1–33;
  - `done` pulse at cycle 34 with `quotient`=14, `remainder`=2, `div_by_zero`=0.
- Signed −7 / 2 (0xFFFFFFF9 / 2):
  - `quotient`=0xFFFFFFFD, `remainder`=0xFFFFFFFF.
  - The same operands unsigned give `quotient`=0x7FFFFFFC, `remainder`=1.
- Signed 0x80000000 / 0xFFFFFFFF → `quotient`=0x80000000, `remainder`=0.
- 1234 / 0 → `done` at cycle 1 with `quotient`=0xFFFFFFFF, `remainder`=1234, `div_by_zero`=1, `busy` never 1.
- Flush, reset and busy-start:
  - Start 100 / 7, assert `flush` at cycle 10 → no `done`; outputs keep the prior results.
  - Start 9 / 3 at cycle 20 → `done` at cycle 54 with `quotient`=3, `remainder`=0.
  - Any `start` pulsed during `busy` is ignored.
  - `reset_n` low at cycle 15 of a divide → outputs are 0 immediately and no `done` follows.
- WIDTH=8, SIGNED_EN=0, `is_signed`=1, 0xF0 / 0x10:
  - `quotient`=0x0F, `remainder`=0 (unsigned treatment);
  - `done` 10 cycles after `start`.
  - A second `start` 0x07 / 0x02 in the `done` cycle → `done` 10 cycles later with `quotient`=3, `remainder`=1.
